regfile_dump_reader: RTL and testbench

- Debug/observability reader for the i281 register file. Drives a read-select port, snapshots registers A-D, then streams them out over a valid/ready byte interface to a debug consumer such as a UART TX or display driver.
- Sits beside the datapath on a dedicated register-file read port. It never writes registers.
- An optional trailing XOR checksum beat follows the register bytes.

---
 rtl/regfile_dump_reader_pkg.sv | 21 ++
 rtl/regfile_dump_reader.sv | 115 +++++++++++
 tb/tb_regfile_dump_reader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared i281 debug definitions: dump FSM states and register-file geometry
// defaults shared with the register file.
package regfile_dump_reader_pkg;

   localparam int unsigned DATA_WIDTH_DEFAULT = 8;
   localparam int unsigned SEL_WIDTH_DEFAULT  = 2;
   localparam int unsigned NUM_REGS_DEFAULT   = 1 << SEL_WIDTH_DEFAULT;
   localparam int unsigned CHECKSUM_INDEX     = NUM_REGS_DEFAULT;

   typedef enum logic [1:0] {
      IDLE,
      SNAP,
      SEND
   } dump_state_t;

   // The checksum beat index sits one past the last register index.
   function automatic int unsigned checksum_index(input int unsigned sel_width);
      return 32'(1) << sel_width;
   endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Snapshots the i281 register file through a dedicated read port and streams
// the captured bytes, plus an optional XOR checksum beat, over valid/ready.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
   parameter int unsigned SEL_WIDTH     = SEL_WIDTH_DEFAULT,
   parameter bit          EMIT_CHECKSUM = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic [SEL_WIDTH-1:0]  rd_sel,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [SEL_WIDTH:0]    out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned NUM_REGS = 1 << SEL_WIDTH;
   localparam int unsigned IDX_W    = SEL_WIDTH + 1;
   localparam logic [IDX_W-1:0] LAST_REG  = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] CSUM_IDX  = IDX_W'(checksum_index(SEL_WIDTH));
   localparam logic [IDX_W-1:0] FINAL_IDX = EMIT_CHECKSUM ? CSUM_IDX : LAST_REG;

   dump_state_t           state;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      next_idx;
   logic [DATA_WIDTH-1:0] checksum;
   logic [DATA_WIDTH-1:0] snap_buf [NUM_REGS];

   assign rd_sel   = idx[SEL_WIDTH-1:0];
   assign next_idx = idx + IDX_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         checksum  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            snap_buf[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SNAP;
                  idx      <= '0;
                  checksum <= '0;
                  busy     <= 1'b1;
               end
            end

            SNAP: begin
               if (abort) begin
                  state <= IDLE;
                  idx   <= '0;
                  busy  <= 1'b0;
               end else begin
                  snap_buf[rd_sel] <= rd_data;
                  checksum         <= checksum ^ rd_data;
                  if (idx == LAST_REG) begin
                     // Slot 0 is only still in flight when the file has a single register.
                     state     <= SEND;
                     idx       <= '0;
                     out_valid <= 1'b1;
                     out_data  <= (idx == '0) ? rd_data : snap_buf[0];
                     out_index <= '0;
                     out_last  <= (FINAL_IDX == '0);
                  end else begin
                     idx <= next_idx;
                  end
               end
            end

            SEND: begin
               if (abort || (out_ready && out_last)) begin
                  // Abort outranks a simultaneous final transfer, so no done then.
                  state     <= IDLE;
                  idx       <= '0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= !abort;
               end else if (out_ready) begin
                  idx       <= next_idx;
                  out_index <= next_idx;
                  out_data  <= (next_idx == CSUM_IDX) ? checksum
                                                      : snap_buf[next_idx[SEL_WIDTH-1:0]];
                  out_last  <= (next_idx == FINAL_IDX);
               end
            end

            default: begin
               state <= IDLE;
               idx   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a small behavioural register file.
module tb_regfile_dump_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [1:0] rd_sel;
   logic [7:0] rd_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_index;
   logic       out_last;
   logic       busy;
   logic       done;

   // Register-file model: synchronous write port, combinational read port.
   logic       we;
   logic [1:0] wa;
   logic [7:0] wd;
   logic [7:0] regs [4];

   int nchecks = 0;
   int nerrors = 0;

   // Results of the most recent collected stream.
   int         nbeats;
   int         ndone;
   logic [7:0] bdata [8];
   logic [2:0] bidx  [8];
   logic       blast [8];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we) regs[wa] <= wd;
   end

   assign rd_data = regs[rd_sel];

   regfile_dump_reader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      we = 1'b1; wa = a; wd = d;
      step();
      we = 1'b0;
   endtask

   // Pulse start, follow the SNAP phase and optionally write the file at edge E0+wr_at+1.
   task automatic kick(input int wr_at, input logic [1:0] wr_a, input logic [7:0] wr_d);
      int lat;
      start = 1'b1;
      step();
      start = 1'b0;
      check("busy_in_snap", 32'(busy), 32'(1));
      lat = 0;
      while (!out_valid && lat < 10) begin
         if (lat < 4) check("rd_sel_snap", 32'(rd_sel), 32'(lat));
         if (lat == wr_at) begin
            we = 1'b1; wa = wr_a; wd = wr_d;
         end
         step();
         we = 1'b0;
         lat++;
      end
      check("valid_latency", 32'(lat), 32'(4));
   endtask

   // Consume the stream; optional stall on one beat and optional start poke after a beat.
   task automatic collect(input int stall_beat, input int stall_len, input int poke_beat);
      int         stalls;
      int         cycles;
      logic       prev_last;
      logic [7:0] held;
      stalls = 0; cycles = 0; nbeats = 0; ndone = 0; prev_last = 1'b0; held = '0;
      while (cycles < 40 && ndone == 0) begin
         start = 1'b0;
         out_ready = 1'b1;
         if (out_valid) begin
            if (32'(out_index) == 32'(stall_beat) && stalls < stall_len) begin
               if (stalls == 0) held = out_data;
               else check("stall_data_stable", 32'(out_data), 32'(held));
               out_ready = 1'b0;
               stalls++;
            end else if (nbeats < 8) begin
               bdata[nbeats] = out_data;
               bidx[nbeats]  = out_index;
               blast[nbeats] = out_last;
               prev_last     = out_last;
               if (nbeats == poke_beat) start = 1'b1;
               nbeats++;
            end
         end
         step();
         cycles++;
         if (done) begin
            ndone++;
            check("valid_low_at_done", 32'(out_valid), 32'(0));
            check("done_after_last", 32'(prev_last), 32'(1));
         end
      end
      start = 1'b0;
      check("stall_cycles", 32'(stalls), 32'(stall_len));
      step();
      check("done_single_pulse", 32'(done), 32'(0));
      check("busy_after_done", 32'(busy), 32'(0));
   endtask

   task automatic check_dump(input logic [39:0] exp);
      check("beat_count", 32'(nbeats), 32'(5));
      for (int i = 0; i < 5; i++) begin
         if (i < nbeats) begin
            check("beat_index", 32'(bidx[i]), 32'(i));
            check("beat_data", 32'(bdata[i]), 32'(exp[8*i +: 8]));
            check("beat_last", 32'(blast[i]), 32'(i == 4));
         end
      end
      check("done_count", 32'(ndone), 32'(1));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      we = 1'b0; wa = '0; wd = '0;
      step();
      wr(2'd0, 8'h11);
      wr(2'd1, 8'h22);
      wr(2'd2, 8'h33);
      wr(2'd3, 8'h44);
      check("rst_rd_sel", 32'(rd_sel), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_data", 32'(out_data), 32'(0));
      check("rst_out_index", 32'(out_index), 32'(0));
      check("rst_out_last", 32'(out_last), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      reset = 1'b0;
      step();

      // Basic dump: 11 22 33 44, checksum 11^22^33^44 = 44.
      kick(-1, 2'd0, 8'h00);
      collect(-1, 0, -1);
      check_dump({8'h44, 8'h44, 8'h33, 8'h22, 8'h11});

      // Backpressure for 3 cycles on beat 1.
      kick(-1, 2'd0, 8'h00);
      collect(1, 3, -1);
      check_dump({8'h44, 8'h44, 8'h33, 8'h22, 8'h11});

      // Write A=AA on the edge after A is captured: snapshot keeps 11.
      kick(1, 2'd0, 8'hAA);
      collect(-1, 0, -1);
      check_dump({8'h44, 8'h44, 8'h33, 8'h22, 8'h11});

      // Next dump sees AA; checksum AA^22^33^44 = FF.
      kick(-1, 2'd0, 8'h00);
      collect(-1, 0, -1);
      check_dump({8'hFF, 8'h44, 8'h33, 8'h22, 8'hAA});

      // Start pulse during SEND beat 2 is ignored.
      kick(-1, 2'd0, 8'h00);
      collect(-1, 0, 2);
      check_dump({8'hFF, 8'h44, 8'h33, 8'h22, 8'hAA});
      check("poke_no_restart", 32'(busy), 32'(0));

      // Abort during SEND beat 1.
      kick(-1, 2'd0, 8'h00);
      out_ready = 1'b1;
      for (int n = 0; n < 10 && !(out_valid && out_index == 3'd1); n++) step();
      check("abort_at_beat1", 32'(out_index), 32'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_valid", 32'(out_valid), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_last", 32'(out_last), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      step();
      check("abort_done_later", 32'(done), 32'(0));
      kick(-1, 2'd0, 8'h00);
      collect(-1, 0, -1);
      check_dump({8'hFF, 8'h44, 8'h33, 8'h22, 8'hAA});

      // Abort together with the final transfer: no done.
      kick(-1, 2'd0, 8'h00);
      out_ready = 1'b1;
      for (int n = 0; n < 10 && !out_last; n++) step();
      check("final_beat_index", 32'(out_index), 32'(4));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_last_done", 32'(done), 32'(0));
      check("abort_last_valid", 32'(out_valid), 32'(0));
      step();
      check("abort_last_done_later", 32'(done), 32'(0));

      // Asynchronous reset in the middle of SNAP.
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("pre_reset_rd_sel", 32'(rd_sel), 32'(2));
      #2 reset = 1'b1;
      #1;
      check("async_rst_rd_sel", 32'(rd_sel), 32'(0));
      check("async_rst_busy", 32'(busy), 32'(0));
      check("async_rst_valid", 32'(out_valid), 32'(0));
      check("async_rst_done", 32'(done), 32'(0));
      step();
      reset = 1'b0;
      step();
      check("post_reset_done", 32'(done), 32'(0));
      kick(-1, 2'd0, 8'h00);
      collect(-1, 0, -1);
      check_dump({8'hFF, 8'h44, 8'h33, 8'h22, 8'hAA});

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
